rr_sel_arb2: RTL and testbench

//  Two-requester round-robin arbiter that generates the select for the downstream mux2x1 data steering stage.

---
 rtl/rr_sel_arb2.sv | 62 ++++++
 tb/tb_rr_sel_arb2.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rr_sel_arb2.sv
// rr_sel_arb2: two-source round-robin arbiter producing the mux2x1 select.
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   [1:0] per-source transfer offer
//   in_ready   [1:0] per-source acceptance
//   out_valid  granted source has a transfer on the mux output
//   out_ready  downstream accepts the mux output
//   sel        mux select, 1 routes source 1
//   gnt        [1:0] one-hot current owner, 00 when idle
module rr_sel_arb2 #(
   parameter int MAX_BURST = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] in_valid,
   output logic [1:0] in_ready,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       sel,
   output logic [1:0] gnt
);
   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] MB = CW'(MAX_BURST);
   typedef enum logic [1:0] {IDLE, G0, G1} state_t;
   state_t state;
   logic last, own, busy, oth, hs;
   logic [CW-1:0] cnt, cnt_n;
   always_comb begin
      gnt       = {state == G1, state == G0};
      busy      = |gnt;
      own       = gnt[1];
      sel       = own;
      oth       = in_valid[~own];
      out_valid = busy & in_valid[own];
      in_ready  = (busy & out_ready) ? (own ? 2'b10 : 2'b01) : 2'b00;
      hs        = out_valid & out_ready;
      cnt_n     = (cnt == MB) ? cnt : cnt + 1'b1;
   end
   // last only moves when ownership is given up, so ties go to the source not served most recently
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         last  <= 1'b1;
         cnt   <= '0;
      end else if (!busy) begin
         cnt <= '0;
         if (|in_valid)
            state <= (&in_valid) ? (last ? G0 : G1) : (in_valid[1] ? G1 : G0);
      end else if (!in_valid[own]) begin
         last  <= own;
         cnt   <= '0;
         state <= oth ? (own ? G0 : G1) : IDLE;
      end else if (hs) begin
         if (oth && cnt_n == MB) begin
            last  <= own;
            cnt   <= '0;
            state <= own ? G0 : G1;
         end else
            cnt <= oth ? cnt_n : '0;
      end
   end
endmodule

// File: tb/tb_rr_sel_arb2.sv
// tb_rr_sel_arb2: directed self-checking bench for rr_sel_arb2 (MAX_BURST 4 and 1).
module tb_rr_sel_arb2;
   logic clk = 0, rst_n = 0, out_ready = 0;
   logic [1:0] in_valid = 0;
   logic [1:0] ir4, ir1, gnt4, gnt1;
   logic ov4, ov1, sel4, sel1;
   logic [5:0] o4, o1;
   int n = 0, f = 0;
   localparam logic [5:0] IDL = 6'b0_00_0_00;
   localparam logic [5:0] G0H = 6'b0_01_1_01;
   localparam logic [5:0] G1H = 6'b1_10_1_10;
   localparam logic [5:0] G0B = 6'b0_01_1_00;
   localparam logic [5:0] G1B = 6'b1_10_1_00;
   localparam logic [5:0] G0D = 6'b0_01_0_01;
   localparam logic [5:0] G1D = 6'b1_10_0_10;
   rr_sel_arb2 #(.MAX_BURST(4)) d4 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4),
      .out_valid(ov4), .out_ready(out_ready), .sel(sel4), .gnt(gnt4));
   rr_sel_arb2 #(.MAX_BURST(1)) d1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
      .out_valid(ov1), .out_ready(out_ready), .sel(sel1), .gnt(gnt1));
   assign o4 = {sel4, gnt4, ov4, ir4};
   assign o1 = {sel1, gnt1, ov1, ir1};
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset;
      rst_n = 0;
      tick();
      rst_n = 1;
   endtask
   task automatic test_reset;
      rst_n = 0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 2'($urandom);
         out_ready = 1'($urandom);
         tick();
         @(negedge clk);
         n++;
         if (o4 !== IDL) begin f++; $display("FAIL reset4 c%0d got %b exp %b", i, o4, IDL); end
         n++;
         if (o1 !== IDL) begin f++; $display("FAIL reset1 c%0d got %b exp %b", i, o1, IDL); end
      end
      in_valid = 0;
      rst_n = 1;
      tick();
   endtask
   task automatic test_single;
      in_valid = 2'b01;
      out_ready = 1;
      @(negedge clk);
      n++;
      if (o4 !== IDL) begin f++; $display("FAIL single_lag got %b exp %b", o4, IDL); end
      tick();
      for (int i = 1; i < 6; i++) begin
         @(negedge clk);
         n++;
         if (o4 !== G0H) begin f++; $display("FAIL single c%0d got %b exp %b", i, o4, G0H); end
         tick();
      end
      in_valid = 2'b00;
      @(negedge clk);
      n++;
      if (o4 !== G0D) begin f++; $display("FAIL single_drop got %b exp %b", o4, G0D); end
      tick();
      @(negedge clk);
      n++;
      if (o4 !== IDL) begin f++; $display("FAIL single_idle got %b exp %b", o4, IDL); end
   endtask
   task automatic test_contention;
      logic [5:0] e;
      do_reset();
      in_valid = 2'b11;
      out_ready = 1;
      tick();
      for (int i = 0; i < 9; i++) begin
         e = ((i / 4) % 2 == 1) ? G1H : G0H;
         @(negedge clk);
         n++;
         if (o4 !== e) begin f++; $display("FAIL contention c%0d got %b exp %b", i, o4, e); end
         tick();
      end
   endtask
   task automatic test_backpressure;
      do_reset();
      in_valid = 2'b11;
      out_ready = 1;
      tick();
      for (int i = 0; i < 4; i++) tick();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n++;
         if (o4 !== G1H) begin f++; $display("FAIL bp_pre c%0d got %b exp %b", i, o4, G1H); end
         tick();
      end
      out_ready = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n++;
         if (o4 !== G1B) begin f++; $display("FAIL bp_hold c%0d got %b exp %b", i, o4, G1B); end
         tick();
      end
      out_ready = 1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n++;
         if (o4 !== G1H) begin f++; $display("FAIL bp_resume c%0d got %b exp %b", i, o4, G1H); end
         tick();
      end
      @(negedge clk);
      n++;
      if (o4 !== G0H) begin f++; $display("FAIL bp_switch got %b exp %b", o4, G0H); end
   endtask
   task automatic test_burst1_drop;
      do_reset();
      in_valid = 2'b11;
      out_ready = 1;
      tick();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n++;
         if (o1 !== ((i % 2 == 1) ? G1H : G0H)) begin
            f++; $display("FAIL alt c%0d got %b exp %b", i, o1, (i % 2 == 1) ? G1H : G0H);
         end
         tick();
      end
      in_valid = 2'b01;
      @(negedge clk);
      n++;
      if (o1 !== G1D) begin f++; $display("FAIL drop1 got %b exp %b", o1, G1D); end
      tick();
      @(negedge clk);
      n++;
      if (o1 !== G0H) begin f++; $display("FAIL drop1_next got %b exp %b", o1, G0H); end
      tick();
      in_valid = 2'b00;
      @(negedge clk);
      n++;
      if (o1 !== G0D) begin f++; $display("FAIL drop_all got %b exp %b", o1, G0D); end
      tick();
      @(negedge clk);
      n++;
      if (o1 !== IDL) begin f++; $display("FAIL drop_idle got %b exp %b", o1, IDL); end
   endtask
   task automatic test_reset_mid;
      do_reset();
      in_valid = 2'b10;
      out_ready = 0;
      tick();
      @(negedge clk);
      n++;
      if (o4 !== G1B) begin f++; $display("FAIL mid_pre got %b exp %b", o4, G1B); end
      in_valid = 2'b11;
      rst_n = 0;
      tick();
      rst_n = 1;
      @(negedge clk);
      n++;
      if (o4 !== IDL) begin f++; $display("FAIL mid_idle got %b exp %b", o4, IDL); end
      tick();
      @(negedge clk);
      n++;
      if (o4 !== G0B) begin f++; $display("FAIL mid_g0 got %b exp %b", o4, G0B); end
      out_ready = 1;
      tick();
      @(negedge clk);
      n++;
      if (o4 !== G0H) begin f++; $display("FAIL mid_hs got %b exp %b", o4, G0H); end
   endtask
   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_burst1_drop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n, f);
      $finish;
   end
endmodule
